// File: rtl/mem_port_arbiter_pkg.sv
// ============================================================================
// Package : dijkstra_mem_pkg
// Brief   : Shared types and constants for the Dijkstra accelerator memory port.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package dijkstra_mem_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE      = 2'd0,
    ARB_ISSUE     = 2'd1,
    ARB_WAIT_RESP = 2'd2,
    ARB_DONE      = 2'd3
  } mem_arb_state_t;

  localparam logic [1:0] MEM_RESP_OKAY   = 2'b00;
  localparam int         MEM_ARB_MAX_REQ = 8;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_port_arbiter_if.sv
// ============================================================================
// Interface : mem_port_arbiter_if
// Brief     : Requester-side and memory-side bundle of the shared memory port.
// Rev       : 1.0  initial release
// ============================================================================
`default_nettype none

interface mem_port_arbiter_if #(
  parameter int NUM_REQ    = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 16
);
  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_write;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_grant;
  logic [NUM_REQ-1:0]            req_done;
  logic                          req_error;
  logic [DATA_WIDTH-1:0]         req_rdata;

  logic [ADDR_WIDTH-1:0]         mem_addr;
  logic                          mem_read_enable;
  logic                          mem_write_enable;
  logic [DATA_WIDTH-1:0]         mem_write_data;
  logic                          wait_request;
  logic                          mem_read_ready;
  logic [DATA_WIDTH-1:0]         mem_read_data;
  logic                          mem_write_ready;
  logic [1:0]                    mem_write_response;

  // Arbiter view
  modport master (
    input  req_valid, req_write, req_addr, req_wdata,
    output req_grant, req_done, req_error, req_rdata,
    output mem_addr, mem_read_enable, mem_write_enable, mem_write_data,
    input  wait_request, mem_read_ready, mem_read_data, mem_write_ready, mem_write_response
  );

  // Requester engines plus memory side
  modport slave (
    output req_valid, req_write, req_addr, req_wdata,
    input  req_grant, req_done, req_error, req_rdata,
    input  mem_addr, mem_read_enable, mem_write_enable, mem_write_data,
    output wait_request, mem_read_ready, mem_read_data, mem_write_ready, mem_write_response
  );
endinterface

`default_nettype wire

// File: rtl/mem_port_arbiter_rr_grant_select.sv
// ============================================================================
// Module : rr_grant_select
// Brief  : Rotate-priority encoder; search starts one past the last winner.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_grant_select #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [IDX_W-1:0]   last_grant,
  output logic [IDX_W-1:0]   winner,
  output logic               any_valid
);

  int w_idx;

  // Walk from the farthest offset back to the nearest so the closest valid wins.
  always_comb begin
    winner    = last_grant;
    any_valid = |req_valid;
    w_idx     = 0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      w_idx = int'(last_grant) + off;
      if (w_idx >= NUM_REQ) w_idx = w_idx - NUM_REQ;
      if (req_valid[w_idx]) winner = IDX_W'(w_idx);
    end
  end

endmodule

`default_nettype wire

// File: rtl/mem_port_arbiter.sv
// ============================================================================
// Module : mem_port_arbiter
// Brief  : Round-robin single-outstanding sequencer for the shared memory port.
//          Optional watchdog timeout enabled by defining MEM_ARB_WATCHDOG_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module mem_port_arbiter
  import dijkstra_mem_pkg::*;
#(
  parameter int NUM_REQ        = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 16,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clock,
  input  logic                reset,
  mem_port_arbiter_if.master  bus
);

  localparam int IDX_W = idx_width(NUM_REQ);

  localparam logic [1:0] c_ST_IDLE      = ARB_IDLE;
  localparam logic [1:0] c_ST_ISSUE     = ARB_ISSUE;
  localparam logic [1:0] c_ST_WAIT_RESP = ARB_WAIT_RESP;
  localparam logic [1:0] c_ST_DONE      = ARB_DONE;

  if (NUM_REQ < 2 || NUM_REQ > MEM_ARB_MAX_REQ ||
      TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_param_check
    $error("mem_port_arbiter: parameter out of range");
  end

  logic [1:0]            r_state;
  logic [IDX_W-1:0]      r_last_grant;
  logic [NUM_REQ-1:0]    r_grant;
  logic [NUM_REQ-1:0]    r_done;
  logic                  r_error;
  logic                  r_write;
  logic                  r_rd_en;
  logic                  r_wr_en;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;

  logic [IDX_W-1:0]      w_winner;
  logic                  w_any_valid;
  logic [NUM_REQ-1:0]    w_winner_onehot;
  logic                  w_timeout;

  rr_grant_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_grant_select (
    .req_valid  (bus.req_valid),
    .last_grant (r_last_grant),
    .winner     (w_winner),
    .any_valid  (w_any_valid)
  );

  assign w_winner_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_winner;

`ifdef MEM_ARB_WATCHDOG_EN
  localparam int WD_RAW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int WD_W   = (WD_RAW < 8) ? 8 : ((WD_RAW > 16) ? 16 : WD_RAW);

  logic [WD_W-1:0] r_wd_cnt;

  // Held at zero outside ISSUE/WAIT_RESP, so it starts from zero on ISSUE entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wd_cnt <= '0;
    end else if (r_state == c_ST_ISSUE || r_state == c_ST_WAIT_RESP) begin
      r_wd_cnt <= r_wd_cnt + 1'b1;
    end else begin
      r_wd_cnt <= '0;
    end
  end

  assign w_timeout = (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= c_ST_IDLE;
      r_last_grant <= IDX_W'(NUM_REQ - 1);
      r_grant      <= '0;
      r_done       <= '0;
      r_error      <= 1'b0;
      r_write      <= 1'b0;
      r_rd_en      <= 1'b0;
      r_wr_en      <= 1'b0;
      r_rdata      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        c_ST_IDLE: begin
          if (w_any_valid) begin
            r_last_grant <= w_winner;
            r_grant      <= w_winner_onehot;
            r_write      <= bus.req_write[w_winner];
            r_addr       <= bus.req_addr[int'(w_winner)*ADDR_WIDTH +: ADDR_WIDTH];
            r_wdata      <= bus.req_wdata[int'(w_winner)*DATA_WIDTH +: DATA_WIDTH];
            r_rd_en      <= ~bus.req_write[w_winner];
            r_wr_en      <= bus.req_write[w_winner];
            r_error      <= 1'b0;
            r_state      <= c_ST_ISSUE;
          end
        end
        c_ST_ISSUE: begin
          // A timeout wins even over a same-cycle acceptance: the owner gets an error.
          if (w_timeout) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_error <= 1'b1;
            r_done  <= r_grant;
            r_state <= c_ST_DONE;
          end else if (!bus.wait_request) begin
            r_rd_en <= 1'b0;
            r_wr_en <= 1'b0;
            r_state <= c_ST_WAIT_RESP;
          end
        end
        c_ST_WAIT_RESP: begin
          if (!r_write && bus.mem_read_ready) begin
            r_rdata <= bus.mem_read_data;
            r_error <= 1'b0;
            r_done  <= r_grant;
            r_state <= c_ST_DONE;
          end else if (r_write && bus.mem_write_ready) begin
            r_error <= (bus.mem_write_response != MEM_RESP_OKAY);
            r_done  <= r_grant;
            r_state <= c_ST_DONE;
          end else if (w_timeout) begin
            r_error <= 1'b1;
            r_done  <= r_grant;
            r_state <= c_ST_DONE;
          end
        end
        c_ST_DONE: begin
          r_grant <= '0;
          r_error <= 1'b0;
          r_state <= c_ST_IDLE;
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  assign bus.req_grant        = r_grant;
  assign bus.req_done         = r_done;
  assign bus.req_error        = r_error;
  assign bus.req_rdata        = r_rdata;
  assign bus.mem_addr         = r_addr;
  assign bus.mem_read_enable  = r_rd_en;
  assign bus.mem_write_enable = r_wr_en;
  assign bus.mem_write_data   = r_wdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
// ============================================================================
// Module : tb_mem_port_arbiter
// Brief  : Directed table-driven bench for mem_port_arbiter (NUM_REQ = 2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mem_port_arbiter;

  localparam int NUM_REQ = 2;
  localparam int AW      = 32;
  localparam int DW      = 16;
  localparam int TMO     = 8;

  typedef struct {
    int          idx;
    bit          wr;
    logic [31:0] addr;
    logic [15:0] wdata;
    int          stalls;
    int          delay;
    logic [15:0] rdata;
    logic [1:0]  resp;
    bit          noise;
    logic [15:0] exp_rdata;
    bit          exp_err;
  } vec_t;

  logic clock = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs [6];

  always #5 clock = ~clock;

  mem_port_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mem_port_arbiter #(
    .NUM_REQ        (NUM_REQ),
    .ADDR_WIDTH     (AW),
    .DATA_WIDTH     (DW),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic mem_quiet();
    bus.mem_read_ready     = 1'b0;
    bus.mem_write_ready    = 1'b0;
    bus.mem_read_data      = 16'h0;
    bus.mem_write_response = 2'b00;
  endtask

  task automatic set_req(input int idx, input bit wr, input logic [31:0] addr, input logic [15:0] wdata);
    bus.req_write[idx]            = wr;
    bus.req_addr[idx*AW +: AW]    = addr;
    bus.req_wdata[idx*DW +: DW]   = wdata;
    bus.req_valid[idx]            = 1'b1;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, " grant"}, 32'(bus.req_grant), 32'h0);
    chk({tag, " done"}, 32'(bus.req_done), 32'h0);
    chk({tag, " error"}, 32'(bus.req_error), 32'h0);
    chk({tag, " rdata"}, 32'(bus.req_rdata), 32'h0);
    chk({tag, " addr"}, bus.mem_addr, 32'h0);
    chk({tag, " wdata"}, 32'(bus.mem_write_data), 32'h0);
    chk({tag, " enables"}, {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h0);
  endtask

  // One isolated transaction; req_done is expected exactly 3+stalls+delay cycles after request.
  task automatic run_vec(input int n, input vec_t v);
    set_req(v.idx, v.wr, v.addr, v.wdata);
    tick();
    for (int k = 0; k <= v.stalls; k++) begin
      chk($sformatf("v%0d rd_en c%0d", n, k), 32'(bus.mem_read_enable), 32'(!v.wr));
      chk($sformatf("v%0d wr_en c%0d", n, k), 32'(bus.mem_write_enable), 32'(v.wr));
      chk($sformatf("v%0d addr c%0d", n, k), bus.mem_addr, v.addr);
      if (v.wr) chk($sformatf("v%0d wdata c%0d", n, k), 32'(bus.mem_write_data), 32'(v.wdata));
      chk($sformatf("v%0d grant c%0d", n, k), 32'(bus.req_grant), 32'(1) << v.idx);
      chk($sformatf("v%0d early done c%0d", n, k), 32'(bus.req_done), 32'h0);
      bus.wait_request = (k < v.stalls);
      if (v.noise) begin
        if (v.wr) begin bus.mem_write_ready = 1'b1; bus.mem_write_response = 2'b11; end
        else      begin bus.mem_read_ready  = 1'b1; bus.mem_read_data      = 16'hDEAD; end
      end
      tick();
      mem_quiet();
    end
    bus.wait_request = 1'b0;
    for (int d = 0; d < v.delay; d++) begin
      chk($sformatf("v%0d en off d%0d", n, d), {30'h0, bus.mem_read_enable, bus.mem_write_enable}, 32'h0);
      chk($sformatf("v%0d wait done d%0d", n, d), 32'(bus.req_done), 32'h0);
      if (v.noise) begin
        if (v.wr) begin bus.mem_read_ready  = 1'b1; bus.mem_read_data      = 16'hDEAD; end
        else      begin bus.mem_write_ready = 1'b1; bus.mem_write_response = 2'b11; end
      end
      tick();
      mem_quiet();
    end
    if (v.wr) begin bus.mem_write_ready = 1'b1; bus.mem_write_response = v.resp; end
    else      begin bus.mem_read_ready  = 1'b1; bus.mem_read_data      = v.rdata; end
    tick();
    mem_quiet();
    chk($sformatf("v%0d done", n), 32'(bus.req_done), 32'(1) << v.idx);
    chk($sformatf("v%0d rdata", n), 32'(bus.req_rdata), 32'(v.exp_rdata));
    chk($sformatf("v%0d error", n), 32'(bus.req_error), 32'(v.exp_err));
    bus.req_valid[v.idx] = 1'b0;
    tick();
    chk($sformatf("v%0d done pulse", n), 32'(bus.req_done), 32'h0);
    chk($sformatf("v%0d grant clr", n), 32'(bus.req_grant), 32'h0);
  endtask

  task automatic do_reset();
    bus.req_valid    = '0;
    bus.wait_request = 1'b0;
    mem_quiet();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int  cnt;
    int  exp_idx;
    bit  seen;

    vecs[0] = '{0, 1'b0, 32'h0000_0010, 16'h0000, 0, 0, 16'h0003, 2'b00, 1'b0, 16'h0003, 1'b0};
    vecs[1] = '{1, 1'b1, 32'h0000_0020, 16'hBEEF, 3, 0, 16'h0000, 2'b10, 1'b0, 16'h0003, 1'b1};
    vecs[2] = '{0, 1'b1, 32'h0000_0030, 16'h1234, 0, 2, 16'h0000, 2'b00, 1'b1, 16'h0003, 1'b0};
    vecs[3] = '{1, 1'b0, 32'h0000_0044, 16'h0000, 1, 1, 16'hA5A5, 2'b00, 1'b1, 16'hA5A5, 1'b0};
    vecs[4] = '{0, 1'b0, 32'hFFFF_FFFC, 16'h0000, 0, 3, 16'hFFFF, 2'b00, 1'b0, 16'hFFFF, 1'b0};
    vecs[5] = '{1, 1'b1, 32'h0000_0022, 16'h0001, 2, 1, 16'h0000, 2'b01, 1'b1, 16'hFFFF, 1'b1};

    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.req_valid = '0;
    bus.wait_request = 1'b0;
    mem_quiet();
    reset = 1'b1;
    tick();
    tick();
    check_reset_state("reset");
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // Fairness: both requesters permanently valid, each drops for one cycle after done.
    do_reset();
    set_req(0, 1'b0, 32'h0000_0100, 16'h0);
    set_req(1, 1'b0, 32'h0000_0200, 16'h0);
    for (int t = 0; t < 4; t++) begin
      exp_idx = t % 2;
      cnt = 0;
      while (!bus.mem_read_enable && cnt < 10) begin tick(); cnt++; end
      chk($sformatf("fair t%0d issued", t), 32'(bus.mem_read_enable), 32'h1);
      chk($sformatf("fair t%0d grant", t), 32'(bus.req_grant), 32'(1) << exp_idx);
      chk($sformatf("fair t%0d addr", t), bus.mem_addr, (exp_idx == 1) ? 32'h200 : 32'h100);
      tick();
      bus.mem_read_ready = 1'b1;
      bus.mem_read_data  = 16'(t + 16'h50);
      tick();
      mem_quiet();
      chk($sformatf("fair t%0d done", t), 32'(bus.req_done), 32'(1) << exp_idx);
      chk($sformatf("fair t%0d rdata", t), 32'(bus.req_rdata), 32'(t + 16'h50));
      bus.req_valid[exp_idx] = 1'b0;
      tick();
      bus.req_valid[exp_idx] = 1'b1;
    end

    // Reset while waiting for the read response; a late ready must be ignored.
    do_reset();
    set_req(1, 1'b0, 32'h0000_0055, 16'h0);
    tick();
    tick();
    chk("rstmid in wait", {30'h0, bus.mem_read_enable, bus.req_grant[1]}, 32'h1);
    bus.req_valid = '0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_reset_state("rstmid");
    bus.mem_read_ready = 1'b1;
    bus.mem_read_data  = 16'h7777;
    tick();
    mem_quiet();
    seen = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (bus.req_done != '0) seen = 1'b1;
      tick();
    end
    chk("rstmid no done", 32'(seen), 32'h0);
    chk("rstmid rdata", 32'(bus.req_rdata), 32'h0);
    set_req(0, 1'b0, 32'h0000_0001, 16'h0);
    set_req(1, 1'b0, 32'h0000_0002, 16'h0);
    tick();
    chk("rstmid next grant", 32'(bus.req_grant), 32'h1);

    // Response never returned.
    do_reset();
    run_vec(6, '{0, 1'b0, 32'h0000_0060, 16'h0, 0, 0, 16'h4242, 2'b00, 1'b0, 16'h4242, 1'b0});
    set_req(0, 1'b0, 32'h0000_0066, 16'h0);
    tick();
    chk("stall issue", 32'(bus.mem_read_enable), 32'h1);
`ifdef MEM_ARB_WATCHDOG_EN
    for (int c = 1; c < TMO; c++) begin
      tick();
      chk($sformatf("wdog quiet c%0d", c), 32'(bus.req_done), 32'h0);
    end
    tick();
    chk("wdog done", 32'(bus.req_done), 32'h1);
    chk("wdog error", 32'(bus.req_error), 32'h1);
    chk("wdog rdata", 32'(bus.req_rdata), 32'h4242);
`else
    seen = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (bus.req_done != '0) seen = 1'b1;
    end
    chk("nowdog no done", 32'(seen), 32'h0);
    chk("nowdog grant held", 32'(bus.req_grant), 32'h1);
    chk("nowdog en off", 32'(bus.mem_read_enable), 32'h0);
`endif
    do_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation did not complete, expected completion before 200000");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Round-robin arbiter and transaction sequencer that shares the single 16-bit memory port of the Dijkstra accelerator between several internal requesters (graph-edge reader, distance-table reader/writer, result writer). It accepts one single-beat read or write per requester, and issues it on the port with the `wait_request` acceptance handshake. It then waits for `mem_read_ready` or `mem_write_ready` and returns data or status to the owner. It sits between the Dijkstra core engines and the memory-side interface; exactly one transaction is outstanding at a time.

## Interface
- `NUM_REQ`, default 2: number of requesters, range 2..8.
- `ADDR_WIDTH`, default 32: memory address width.
- `DATA_WIDTH`, default 16: memory data width.
- `TIMEOUT_CYCLES`, default 255: watchdog limit. Used only with `MEM_ARB_WATCHDOG_EN`.
- `clock` in 1: single clock for all logic.
- `reset` in 1: synchronous, active-high.
- `req_valid` in NUM_REQ: request pending, one bit per requester.
- `req_write` in NUM_REQ: 1 = write, 0 = read, per requester.
- `req_addr` in NUM_REQ*ADDR_WIDTH: packed addresses; requester i is at slice [i*ADDR_WIDTH +: ADDR_WIDTH].
- `req_wdata` in NUM_REQ*DATA_WIDTH: packed write data.
- `req_grant` out NUM_REQ: one-hot owner of the port, held from ISSUE through DONE.
- `req_done` out NUM_REQ: one-cycle completion pulse to the owner.
- `req_error` out 1: qualifies `req_done`; 1 = write response not OKAY, or timeout.
- `req_rdata` out DATA_WIDTH: read data, valid while `req_done` is high.
- `mem_addr` out ADDR_WIDTH: memory address.
- `mem_read_enable` out 1: memory read command.
- `mem_write_enable` out 1: memory write command.
- `mem_write_data` out DATA_WIDTH: memory write data.
- `wait_request` in 1: memory stall. The command is accepted in the cycle an enable is high and `wait_request` is low.
- `mem_read_ready` in 1: read data valid on `mem_read_data`.
- `mem_read_data` in DATA_WIDTH: read return data.
- `mem_write_ready` in 1: write complete, `mem_write_response` valid.
- `mem_write_response` in 2: write status; 2'b00 = OKAY, any other value = error.

## Operation
- FSM states: IDLE, ISSUE, WAIT_RESP, DONE.
- IDLE:
  - If any `req_valid` is high, select the winner round-robin, starting at `last_grant+1` and wrapping modulo NUM_REQ.
  - Latch the winner's index, op, addr and wdata into registers.
  - Set `last_grant` to the winner and go to ISSUE.
- ISSUE:
  - Registered `mem_addr`, `mem_write_data` and the relevant enable are held stable.
  - When `wait_request` is low, drop the enable and go to WAIT_RESP.
- WAIT_RESP:
  - For a read, wait for `mem_read_ready`; capture `mem_read_data` into `req_rdata`.
  - For a write, wait for `mem_write_ready`; set `req_error = (mem_write_response != 2'b00)`.
  - On the matching ready, go to DONE.
  - The ready signal that does not match the latched op is ignored.
- DONE:
  - Pulse `req_done[owner]` for one cycle.
  - Clear the grant on exit and return to IDLE.
- Requesters hold `req_valid`, addr and wdata stable until their `req_done`, then deassert `req_valid` for at least one cycle.
- Changes on a non-granted requester's inputs never affect the transaction in flight.
- Ready or response pulses arriving in IDLE or ISSUE are ignored.
- Write data is not returned: `req_rdata` keeps its last read value.

## Timing
- Reset values:
  - state IDLE, `last_grant` = NUM_REQ-1, so requester 0 wins first.
  - All enables, `req_grant`, `req_done` and `req_error` are 0.
  - `req_rdata`, `mem_addr` and `mem_write_data` are 0.
- Reset asserted mid-transaction aborts at the next edge. No `req_done` is issued and any late ready is ignored.
- Minimum latency, with `wait_request` low and ready returned in the cycle after acceptance:
  - cycle 0: `req_valid` sampled.
  - cycle 1: enable high and accepted.
  - cycle 2: ready sampled.
  - cycle 3: `req_done` pulse.
  - Next arbitration is at cycle 4.
- Each `wait_request` stall cycle adds one cycle; each cycle of missing ready adds one cycle.
- Fairness: with all requesters permanently valid, grants rotate 0,1,...,NUM_REQ-1,0.

## Configuration
- `MEM_ARB_WATCHDOG_EN` defined:
  - An 8..16-bit counter counts consecutive cycles spent in ISSUE plus WAIT_RESP.
  - It resets on entering ISSUE.
  - When it reaches TIMEOUT_CYCLES: drop enables, go to DONE, and pulse `req_done` with `req_error` = 1 and `req_rdata` unchanged.
- Not defined: no counter exists; the FSM waits indefinitely and `req_error` reflects only the write response.

## Structure
- Shared package `dijkstra_mem_pkg` holds:
  - the state enum `mem_arb_state_t`;
  - constants `MEM_RESP_OKAY = 2'b00`, `MEM_ARB_MAX_REQ = 8`.
- One sub-module, `rr_grant_select`: combinational rotate-priority encoder.
  - Inputs: `req_valid` and `last_grant`.
  - Outputs: winner index and any-valid flag.
- The FSM and registers live in `mem_port_arbiter`.

## Test plan
- Single read, requester 0, addr 0x10, `wait_request` low, `mem_read_data` 0x0003 one cycle after acceptance -> `req_done[0]` at cycle 3, `req_rdata` = 0x0003, `req_error` = 0.
- Both requesters valid continuously for 4 transactions -> grants in order 0,1,0,1; `mem_addr` matches each owner's address.
- Write, addr 0x20, data 0xBEEF, `wait_request` high 3 cycles -> `mem_write_enable` held 4 cycles with stable addr/data. With response 2'b10: `req_done` pulses with `req_error` = 1.
- `reset` asserted during WAIT_RESP, then `mem_read_ready` pulsed -> no `req_done`, all outputs 0, next grant goes to requester 0.
- With `MEM_ARB_WATCHDOG_EN`, TIMEOUT_CYCLES = 8, no ready returned -> `req_done` with `req_error` = 1 exactly 8 cycles after ISSUE entry. Without the macro: still waiting after 100 cycles.
